// File: rtl/regfile_write_scheduler.sv
// ALU/load writeback arbiter: both sources share one in-order queue feeding the single register-file write port; REGWB_BYPASS_EN adds a youngest-match forwarding search.
// Latency: request accepted at edge N, output stage loaded at N+1, register file written at N+2; one write per cycle sustained.
// Backpressure: readiness derives from registered COUNT only (same-edge pop not credited); the ALU wins the last free slot over memory.
module regfile_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     A_VALID,
    input  logic [2:0]               A_ADDR,
    input  logic [7:0]               A_DATA,
    output logic                     A_READY,
    input  logic                     M_VALID,
    input  logic [2:0]               M_ADDR,
    input  logic [7:0]               M_DATA,
    output logic                     M_READY,
    output logic                     WRITE,
    output logic [2:0]               INADDRESS,
    output logic [7:0]               IN,
    output logic [7:0]               PENDING,
    output logic [$clog2(DEPTH):0]   COUNT
`ifdef REGWB_BYPASS_EN
    ,
    input  logic [2:0]               BYP_ADDR,
    output logic                     BYP_HIT,
    output logic [7:0]               BYP_DATA
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] FULL    = NW'(DEPTH);
    localparam logic [NW-1:0] FULL_M1 = NW'(DEPTH - 1);

    logic [2:0]    q_addr [DEPTH];
    logic [7:0]    q_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [NW-1:0] count_q;

    logic [CW-1:0] pend_q   [8];
    logic [CW-1:0] pend_nxt [8];

    logic          a_push;
    logic          m_push;
    logic          pop;
    logic [AW-1:0] m_slot;
    logic [NW-1:0] count_nxt;

    assign COUNT = count_q;

    always_comb begin
        A_READY   = (count_q < FULL);
        M_READY   = (count_q < FULL_M1) || ((count_q < FULL) && !A_VALID);
        a_push    = A_VALID && A_READY;
        m_push    = M_VALID && M_READY;
        pop       = (count_q != '0);
        // When both push on one edge, A takes the older slot.
        m_slot    = wr_ptr + AW'(a_push);
        count_nxt = count_q + NW'(a_push) + NW'(m_push) - NW'(pop);
    end

    // Queue storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge CLK) begin
        if (a_push) begin
            q_addr[wr_ptr] <= A_ADDR;
            q_data[wr_ptr] <= A_DATA;
        end
        if (m_push) begin
            q_addr[m_slot] <= M_ADDR;
            q_data[m_slot] <= M_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
        end else begin
            rd_ptr  <= rd_ptr + AW'(pop);
            wr_ptr  <= wr_ptr + AW'(a_push) + AW'(m_push);
            count_q <= count_nxt;
            WRITE   <= pop;
            if (pop) begin
                INADDRESS <= q_addr[rd_ptr];
                IN        <= q_data[rd_ptr];
            end
        end
    end

    // Each counter tracks writes to its register still in the queue or output stage.
    always_comb begin
        PENDING = '0;
        for (int r = 0; r < 8; r++) begin
            pend_nxt[r] = pend_q[r]
                        + CW'(a_push && (A_ADDR == 3'(r)))
                        + CW'(m_push && (M_ADDR == 3'(r)))
                        - CW'(WRITE && (INADDRESS == 3'(r)));
            PENDING[r]  = (pend_q[r] != '0);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int r = 0; r < 8; r++) pend_q[r] <= '0;
        end else begin
            for (int r = 0; r < 8; r++) pend_q[r] <= pend_nxt[r];
        end
    end

`ifdef REGWB_BYPASS_EN
    logic [AW-1:0] byp_idx;

    // Scan oldest to youngest so the last match seen is the youngest write.
    always_comb begin
        BYP_HIT  = 1'b0;
        BYP_DATA = '0;
        byp_idx  = '0;
        if (WRITE && (INADDRESS == BYP_ADDR)) begin
            BYP_HIT  = 1'b1;
            BYP_DATA = IN;
        end
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr + AW'(i);
            if ((NW'(i) < count_q) && (q_addr[byp_idx] == BYP_ADDR)) begin
                BYP_HIT  = 1'b1;
                BYP_DATA = q_data[byp_idx];
            end
        end
    end
`endif

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the register file's single write port (8 regs x 8-bit, synchronous write, `WRITE`/`INADDRESS`/`IN`) between two writeback sources: ALU result and memory load.
- Both sources push requests into one shared in-order queue. The queue drains at one write per cycle into a registered output stage that drives the register-file write port.
- Maintains a per-register pending mask so decode can stall on read-after-write hazards.

Parameters:
- `DEPTH`, 4, shared queue entries; power of two, >= 2.
- `CW`, 3, per-register pending-counter width; must hold `DEPTH`+1.

Ports:
- `CLK`  in  1  system clock, all state on posedge.
- `RESET`  in  1  asynchronous, active-low reset.
- `A_VALID`  in  1  ALU writeback request.
- `A_ADDR`  in  3  ALU destination register.
- `A_DATA`  in  8  ALU result (signed).
- `A_READY`  out  1  ALU request accepted this edge if `A_VALID`.
- `M_VALID`  in  1  memory writeback request.
- `M_ADDR`  in  3  memory destination register.
- `M_DATA`  in  8  load data (signed).
- `M_READY`  out  1  memory request accepted this edge if `M_VALID`.
- `WRITE`  out  1  register-file write enable (registered).
- `INADDRESS`  out  3  register-file write address (registered).
- `IN`  out  8  register-file write data (registered).
- `PENDING`  out  8  bit r = 1 while any write to Rr is queued or in the output stage.
- `COUNT`  out  log2(`DEPTH`)+1  queue occupancy (output stage excluded).

Behaviour:
- **Reset (`RESET`=0, async):**
  - Queue emptied; `COUNT`=0.
  - `WRITE`=0, `INADDRESS`=0, `IN`=0.
  - All pending counters 0, `PENDING`=0.
  - Queued writes are discarded, including mid-drain.
- **Ready (from registered `COUNT` only; same-cycle pop is not credited):**
  - `A_READY` = (`COUNT` < `DEPTH`).
  - `M_READY` = (`COUNT` < `DEPTH`-1) OR (`COUNT` < `DEPTH` AND !`A_VALID`).
- **Enqueue:**
  - Transfer occurs on posedge when VALID and READY.
  - Same-edge A and M: A is written first (older), M second.
- **Drain:**
  - Each posedge with `COUNT`>0, the head pops into the output stage: `WRITE`=1, `INADDRESS`/`IN` = head.
  - With `COUNT`=0: `WRITE`=0; `INADDRESS`/`IN` hold their last values.
  - Pop and up to two pushes may occur on the same edge; `COUNT` updates by the net change.
- **Latency (empty queue):**
  - Request accepted at edge N.
  - Output stage loaded at edge N+1.
  - Register file writes at edge N+2.
  - Sustained throughput: 1 write/cycle; excess input is back-pressured.
- **Ordering:**
  - Strict global acceptance order.
  - Multiple queued writes to the same register retire in order; the last accepted write wins.
- **Pending:**
  - Counter[r] increments per accepted request with addr r; the same edge with both A and M to r gives +2.
  - Counter[r] decrements on each edge where `WRITE`=1 and `INADDRESS`=r (the retirement edge).
  - Increment and decrement on the same edge are netted.
  - `PENDING`[r] = (counter[r] != 0).
- **Queue structure:**
  - Circular buffer; read/write pointers wrap modulo `DEPTH`.
  - Full/empty are distinguished by `COUNT`.
- VALID without READY is not an error; the source holds its request.

Optional Feature:
- Macro: `REGWB_BYPASS_EN`.
- Defined: adds ports `BYP_ADDR` in 3, `BYP_HIT` out 1, `BYP_DATA` out 8.
  - Combinational search of output stage plus queue for the youngest entry with addr == `BYP_ADDR`.
  - `BYP_HIT`=1 with that data when found; else `BYP_HIT`=0 and `BYP_DATA`=0.
  - The output stage counts only while `WRITE`=1.
- Undefined: ports absent, no search logic; behaviour otherwise identical.

Test Plan:
- Reset, then `A_VALID`=1, `A_ADDR`=3, `A_DATA`=0x5A for one cycle.
  -> `PENDING`=0x08 after edge 1; `WRITE`=1, `INADDRESS`=3, `IN`=0x5A after edge 2; R3=0x5A and `PENDING`=0 after edge 3.
- Same edge: A (R1, 0x11) and M (R1, 0x22) on an empty queue.
  -> Two consecutive writes, 0x11 then 0x22; R1 ends 0x22; `PENDING`[1] stays 1 until the second write retires.
- Hold `A_VALID`=1 with distinct addresses every cycle while forcing `M_VALID`=1 to `DEPTH`=4.
  -> `COUNT` saturates; `A_READY`/`M_READY` drop per the rules; no request lost or duplicated; retirement order equals acceptance order.
- `COUNT`=3, A and M both valid.
  -> `A_READY`=1, `M_READY`=0; A accepted, M accepted on a later edge.
- Assert `RESET`=0 asynchronously between edges with 3 entries queued.
  -> `WRITE`, `COUNT`, `PENDING` go 0 immediately; no further writes occur after release.
- With `REGWB_BYPASS_EN`: queue R5=0x10 then R5=0x7F, `BYP_ADDR`=5.
  -> `BYP_HIT`=1, `BYP_DATA`=0x7F; with `BYP_ADDR`=2 -> `BYP_HIT`=0.
